// File: rtl/vec_feeder_if.sv
// Streaming-input and engine-read bundle for vec_feeder.
// The feeder sits on the slave modport; the stream source and the engine drive the master side.
interface vec_feeder_if #(
   parameter int BITWIDTH      = 18,
   parameter int ADDR_BITWIDTH = 4
) ();
   logic [BITWIDTH-1:0]      s_data;
   logic                     s_valid;
   logic                     s_ready;
   logic [ADDR_BITWIDTH-1:0] colAddress;
   logic                     vecRelease;
   logic [BITWIDTH-1:0]      inputVector;
   logic                     vecValid;
   logic                     vecStart;

   modport master (
      output s_data, s_valid, colAddress, vecRelease,
      input  s_ready, inputVector, vecValid, vecStart
   );

   modport slave (
      input  s_data, s_valid, colAddress, vecRelease,
      output s_ready, inputVector, vecValid, vecStart
   );
endinterface

// File: rtl/vec_feeder.sv
// Double-buffered vector feeder: streams elements into a fill bank while the engine reads the active bank.
// Define VEC_FEEDER_REGOUT_EN to register inputVector (one cycle of read latency).
module vec_feeder #(
   parameter int NCOL          = 16,
   parameter int BITWIDTH      = 18,
   parameter int ADDR_BITWIDTH = 4
) (
   input logic           clk,
   input logic           reset,
   vec_feeder_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

   localparam logic [ADDR_BITWIDTH-1:0] LAST_PTR = ADDR_BITWIDTH'(NCOL - 1);
   localparam logic [ADDR_BITWIDTH:0]   NCOL_W   = (ADDR_BITWIDTH + 1)'(NCOL);

   state_t                   state_q, state_d;
   logic [ADDR_BITWIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic                     sel_q, sel_d;
   logic                     vec_start_q, vec_start_d;
   logic [BITWIDTH-1:0]      bank_q [2][NCOL];

   logic                     s_ready;
   logic                     vec_valid;
   logic                     accept;
   logic                     complete;
   logic                     swap;
   logic                     col_in_range;
   logic [BITWIDTH-1:0]      rd_data;

   assign s_ready      = !reset && (state_q != STALL);
   assign vec_valid    = (state_q == RUN) || (state_q == STALL);
   assign accept       = bus.s_valid && s_ready;
   assign complete     = accept && (wr_ptr_q == LAST_PTR);
   assign col_in_range = {1'b0, bus.colAddress} < NCOL_W;

   // Bank roles swap by flipping sel; a release only matters once a vector is active.
   always_comb begin
      state_d     = state_q;
      swap        = 1'b0;
      wr_ptr_d    = wr_ptr_q;
      if (accept) begin
         wr_ptr_d = complete ? '0 : wr_ptr_q + ADDR_BITWIDTH'(1);
      end
      case (state_q)
         IDLE: begin
            if (complete) begin
               state_d = RUN;
               swap    = 1'b1;
            end
         end
         RUN: begin
            if (complete && bus.vecRelease) begin
               swap = 1'b1;
            end else if (complete) begin
               state_d = STALL;
            end else if (bus.vecRelease) begin
               state_d = IDLE;
            end
         end
         STALL: begin
            if (bus.vecRelease) begin
               state_d = RUN;
               swap    = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      sel_d       = sel_q ^ swap;
      vec_start_d = swap;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         sel_q       <= 1'b0;
         vec_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         sel_q       <= sel_d;
         vec_start_q <= vec_start_d;
      end
   end

   // Storage is never reset; the state and pointer decide what is meaningful.
   always_ff @(posedge clk) begin
      if (accept) begin
         bank_q[~sel_q][wr_ptr_q] <= bus.s_data;
      end
   end

   assign rd_data = (vec_valid && col_in_range) ? bank_q[sel_q][bus.colAddress] : '0;

`ifdef VEC_FEEDER_REGOUT_EN
   logic [BITWIDTH-1:0] vec_out_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         vec_out_q <= '0;
      end else begin
         vec_out_q <= rd_data;
      end
   end

   assign bus.inputVector = vec_out_q;
`else
   assign bus.inputVector = rd_data;
`endif

   assign bus.s_ready  = s_ready;
   assign bus.vecValid = vec_valid;
   assign bus.vecStart = vec_start_q;
endmodule
